// File: rtl/mulu_ddr_pkg.sv
// mulu_ddr_pkg: output mode encodings and per-channel half-word index helper
package mulu_ddr_pkg;
  localparam logic [1:0] MODE_DDR  = 2'b00;
  localparam logic [1:0] MODE_SDR  = 2'b01;
  localparam logic [1:0] MODE_SWAP = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;
  function automatic int half_lsb(input int c, input int w, input logic pos);
    return c * 2 * w + (pos ? w : 0);
  endfunction
endpackage

// File: rtl/fifo_sync.sv
// fifo_sync: synchronous FIFO with wrap-bit pointers
// ports: clk, rst, push/wdata in, pop in, rdata = head (combinational), full, empty, level
module fifo_sync #(
  parameter int DW    = 14,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DW-1:0]                wdata,
  output logic [DW-1:0]                rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign level = wr_ptr - rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  // same slot, opposite lap
  assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign rdata = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/mux_clk_edge_out_ser.sv
// mux_clk_edge_out_ser: FIFO-buffered DDR output serializer (pos half while clk high, neg half while low)
// ports: clk, rst, in_data/in_valid/in_ready, mode, idle_pat, out, out_valid, underrun (sticky), level
module mux_clk_edge_out_ser
  import mulu_ddr_pkg::*;
#(
  parameter int WIDTH    = 7,
  parameter int CHANNELS = 1,
  parameter int DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS*2*WIDTH-1:0]   in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    mode,
  input  logic [WIDTH-1:0]              idle_pat,
  output logic [CHANNELS*WIDTH-1:0]     out,
  output logic                          out_valid,
  output logic                          underrun,
  output logic [$clog2(DEPTH+1)-1:0]    level
);
  localparam int DW = CHANNELS * 2 * WIDTH;
  logic [DW-1:0] head;
  logic full, empty, push, pop, pop_mode, armed;
  logic [CHANNELS*WIDTH-1:0] pos_q, neg_q, nxt_pos, nxt_neg;
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop_mode = mode != MODE_HOLD;
  assign pop      = pop_mode && !empty;
  fifo_sync #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );
  // pos_q takes the neg half only in SWAP; neg_q takes the pos half in SDR and SWAP
  always_comb begin
    nxt_pos = '0;
    nxt_neg = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      nxt_pos[c*WIDTH +: WIDTH] = empty ? idle_pat : head[half_lsb(c, WIDTH, mode != MODE_SWAP) +: WIDTH];
      nxt_neg[c*WIDTH +: WIDTH] = empty ? idle_pat : head[half_lsb(c, WIDTH, mode != MODE_DDR) +: WIDTH];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {pos_q, neg_q, out_valid, underrun, armed} <= '0;
    end else begin
      armed <= armed | push;
      if (pop_mode) begin
        pos_q     <= nxt_pos;
        neg_q     <= nxt_neg;
        out_valid <= !empty;
        underrun  <= underrun | (empty & armed);
      end
    end
  end
  assign out = clk ? pos_q : neg_q;
endmodule

// File: tb/tb_mux_clk_edge_out_ser.sv
// tb_mux_clk_edge_out_ser: queue-model checker plus directed literal checks, CHANNELS=2
module tb_mux_clk_edge_out_ser;
  localparam int W = 7, CH = 2, D = 4;
  logic clk, rst, in_valid, in_ready, out_valid, underrun;
  logic [CH*2*W-1:0] in_data;
  logic [1:0] mode;
  logic [W-1:0] idle_pat;
  logic [CH*W-1:0] out;
  logic [2:0] level;
  int errors = 0, checks = 0;
  mux_clk_edge_out_ser #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .idle_pat(idle_pat), .out(out), .out_valid(out_valid),
    .underrun(underrun), .level(level)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  logic [CH*2*W-1:0] q[$];
  logic [CH*2*W-1:0] w;
  logic [CH*W-1:0] e_pos, e_neg;
  logic e_valid, e_under, e_armed, acc;
  logic [W-1:0] ph, nh;
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        e_pos = '0; e_neg = '0; e_valid = 0; e_under = 0; e_armed = 0;
      end else begin
        acc = in_valid && q.size() < D;
        if (mode != 2'b11) begin
          if (q.size() == 0) begin
            e_pos = {CH{idle_pat}};
            e_neg = {CH{idle_pat}};
            e_valid = 0;
            if (e_armed) e_under = 1;
          end else begin
            w = q.pop_front();
            for (int c = 0; c < CH; c++) begin
              ph = w[c*2*W+W +: W];
              nh = w[c*2*W +: W];
              case (mode)
                2'b00: begin e_pos[c*W +: W] = ph; e_neg[c*W +: W] = nh; end
                2'b01: begin e_pos[c*W +: W] = ph; e_neg[c*W +: W] = ph; end
                default: begin e_pos[c*W +: W] = nh; e_neg[c*W +: W] = ph; end
              endcase
            end
            e_valid = 1;
          end
        end
        if (acc) begin
          q.push_back(in_data);
          e_armed = 1;
        end
      end
      #1;
      chk("m_out_hi", out, e_pos);
      chk("m_valid", out_valid, e_valid);
      chk("m_underrun", underrun, e_under);
      chk("m_level", level, 32'(q.size()));
      chk("m_ready", in_ready, q.size() < D);
      @(negedge clk);
      #1;
      chk("m_out_lo", out, e_neg);
    end
  end
  initial begin
    rst = 1; in_valid = 0; in_data = '0; mode = 2'b00; idle_pat = 7'h2A;
    @(posedge clk); #2;
    chk("rst_out_hi", out, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", in_ready, 1);
    @(negedge clk); #2;
    chk("rst_out_lo", out, 0);
    rst = 0;
    @(posedge clk); #2;
    chk("idle_hi", out, {2{7'h2A}});
    chk("idle_valid", out_valid, 0);
    chk("idle_under", underrun, 0);
    @(negedge clk); #2;
    chk("idle_lo", out, {2{7'h2A}});
    in_valid = 1; in_data = {7'h33, 7'h44, 7'h55, 7'h0F};
    @(posedge clk); #2;
    in_valid = 0;
    @(posedge clk); #2;
    chk("ddr_hi", out, {7'h33, 7'h55});
    chk("ddr_valid", out_valid, 1);
    @(negedge clk); #2;
    chk("ddr_lo", out, {7'h44, 7'h0F});
    @(posedge clk); #2;
    chk("ddr_idle", out, {2{7'h2A}});
    chk("ddr_underrun", underrun, 1);
    mode = 2'b11; in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      in_data = {7'(4*k+1), 7'(4*k+2), 7'(4*k+3), 7'(4*k+4)};
      @(posedge clk); #2;
    end
    chk("full_ready", in_ready, 0);
    chk("full_level", level, 4);
    in_valid = 0; mode = 2'b00;
    @(posedge clk); #2;
    chk("drain_first", out, {7'h01, 7'h03});
    chk("drain_ready", in_ready, 1);
    chk("drain_level", level, 3);
    repeat (5) @(posedge clk);
    #2;
    mode = 2'b10; in_valid = 1; in_data = {7'h66, 7'h77, 7'h11, 7'h22};
    @(posedge clk); #2;
    in_valid = 0;
    @(posedge clk); #2;
    chk("swap_hi", out, {7'h77, 7'h22});
    @(negedge clk); #2;
    chk("swap_lo", out, {7'h66, 7'h11});
    mode = 2'b01; in_valid = 1;
    @(posedge clk); #2;
    in_valid = 0;
    @(posedge clk); #2;
    chk("sdr_hi", out, {7'h66, 7'h11});
    @(negedge clk); #2;
    chk("sdr_lo", out, {7'h66, 7'h11});
    mode = 2'b00; in_valid = 1;
    for (int k = 0; k < 8; k++) begin
      in_data = {7'(k+20), 7'(k+40), 7'(k+60), 7'(k+80)};
      @(posedge clk); #2;
    end
    chk("steady_level", level, 1);
    chk("steady_out", out, {7'd26, 7'd66});
    in_valid = 0;
    @(posedge clk); #2;
    mode = 2'b11; in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      in_data = {4{7'(k+100)}};
      @(posedge clk); #2;
    end
    chk("mid_level", level, 3);
    rst = 1;
    @(posedge clk); #2;
    chk("rst2_hi", out, 0);
    chk("rst2_level", level, 0);
    chk("rst2_under", underrun, 0);
    @(negedge clk); #2;
    chk("rst2_lo", out, 0);
    rst = 0; in_valid = 0; mode = 2'b00;
    @(posedge clk); #2;
    chk("post_idle", out, {2{7'h2A}});
    chk("post_valid", out_valid, 0);
    repeat (3) @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mux_clk_edge_out_ser.md
# mux_clk_edge_out_ser

Parametrised DDR output serializer for the multiplier result path. It buffers multi-channel result words in a small synchronous FIFO and drives each word onto the output pins in two halves: the "pos" half while `clk` is high and the "neg" half while `clk` is low. It adds a valid/ready handshake, a run-time output mode, an idle pattern and underrun detection on top of the plain clock-level output mux. It sits between the multiplier result register and the top-level `uo_out` pins.

## Interface
Parameters:
- `WIDTH`, 7, bits per half-word per channel; pin width per channel.
- `CHANNELS`, 1, independent lanes driven in lockstep.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; rising edge for all state; its level also selects the output half.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  `CHANNELS*2*WIDTH`  per channel c: bits [c*2W+2W-1 : c*2W+W] = pos half, [c*2W+W-1 : c*2W] = neg half.
- `in_valid`  in  1  producer has a word.
- `in_ready`  out  1  FIFO not full.
- `mode`  in  2  output mode, sampled at each rising edge.
- `idle_pat`  in  `WIDTH`  pattern driven on every channel when no data.
- `out`  out  `CHANNELS*WIDTH`  pin data, `clk ? pos_q : neg_q`.
- `out_valid`  out  1  registered; current `out` word comes from the FIFO.
- `underrun`  out  1  sticky; FIFO ran dry after the first accepted word.
- `level`  out  `$clog2(DEPTH+1)`  FIFO occupancy.

## Operation
- Push when `in_valid && in_ready`. `in_ready = (level != DEPTH)`. There is no pass-through when full: a push and a pop in the same edge while full is impossible because `in_ready` is 0.
- Output registers `pos_q` and `neg_q` (per channel) load at every rising edge, by `mode`:
  - `2'b00 DDR`: pop head; `pos_q` = pos half, `neg_q` = neg half.
  - `2'b01 SDR`: pop head; both registers = pos half. The neg half is discarded.
  - `2'b10 SWAP`: pop head; `pos_q` = neg half, `neg_q` = pos half.
  - `2'b11 HOLD`: no pop; `pos_q`, `neg_q` and `out_valid` keep their values.
- FIFO empty in a popping mode: both registers load `idle_pat` on every channel and `out_valid` is 0. If an `armed` flag is set, `underrun` is set to 1.
- `armed` is set by the first accepted push after reset. `underrun` stays set until `rst`.
- Simultaneous push and pop: `level` is unchanged. The head popped is the older entry, never the word being pushed this edge.
- Reset (any time, including mid-stream):
  - FIFO flushed; `level` = 0.
  - `pos_q` = `neg_q` = 0, so `out` = 0 in both phases.
  - `out_valid` = 0, `underrun` = 0, `armed` = 0, `in_ready` = 1.
  - `idle_pat` is first driven at the first rising edge after `rst` deasserts.
- `out` is a level-selected mux driven by `clk`, not a register. Each pin's full-cycle content is "pos half during the high phase, neg half during the low phase".

## Timing
- Push-to-pin latency with an empty FIFO: word accepted at edge N is popped at edge N+1. Its pos half is on `out` during the high phase after N+1, and its neg half during the following low phase.
- Throughput: one word per cycle in DDR, SDR and SWAP modes. `in_valid` held high for `DEPTH` cycles with no pops (HOLD) fills the FIFO.
- `level`, `in_ready`, `out_valid` and `underrun` are all registered or derived from registers; none depends on `clk` level.
- A mode change takes effect at the edge where it is sampled. Data already in `pos_q`/`neg_q` is not re-ordered.

## Structure
- Package `mulu_ddr_pkg` holds `MODE_DDR`, `MODE_SDR`, `MODE_SWAP` and `MODE_HOLD` as 2-bit localparams, plus the half-select helper index function.
- Sub-module `fifo_sync` (params `DW`, `DEPTH`) provides the storage: wrap-around read/write pointers with an extra wrap bit, and `level`. The serializer top contains only the output registers, mode logic, the underrun/armed flags and the clock-level mux.

## Test plan
- Reset, then idle, with `idle_pat=7'h2A`, DDR mode: `out=0` during `rst`; from the first edge after release `out=7'h2A` in both phases, `out_valid=0`, `underrun=0`.
- DDR, single push of pos `7'h55` / neg `7'h0F` at edge N: at N+1 `out_valid=1`, `out=7'h55` while `clk` high and `7'h0F` while low. At N+2 `out` returns to idle and `underrun=1`.
- HOLD mode with 5 consecutive pushes, `DEPTH=4`: `in_ready` drops after the 4th push, `level=4`, the 5th word is not accepted. Switching to DDR drains the words in order at one per cycle, and `in_ready` returns after the first pop.
- SWAP and SDR with word pos `7'h11` / neg `7'h22`: SWAP shows high=`7'h22`, low=`7'h11`; SDR shows `7'h11` in both phases.
- `CHANNELS=2`, simultaneous push and pop at steady state: `level` is constant, each lane shows its own halves, and order is preserved.
- Assert `rst` for one cycle with `level=3` mid-stream: `out=0`, `level=0`, `underrun=0`, and the flushed words never appear on `out`.
